// File: rtl/reg_file_if.sv
// Register-file access bus: shared write data, function/enable selects,
// and the two read-port selects with their data outputs.
interface reg_file_if #(
  parameter int N = 8
);
  logic [N-1:0] i;
  logic [1:0]   fun_sel;
  logic [3:0]   reg_sel;
  logic [1:0]   out_a_sel;
  logic [1:0]   out_b_sel;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;

  // The datapath controller drives selects and write data, reads operands.
  modport master (
    output i, fun_sel, reg_sel, out_a_sel, out_b_sel,
    input  out_a, out_b
  );

  // The register file consumes selects and write data, returns operands.
  modport slave (
    input  i, fun_sel, reg_sel, out_a_sel, out_b_sel,
    output out_a, out_b
  );
endinterface

// File: rtl/reg_file.sv
// Four-entry general-purpose register file (R1..R4).
// Each entry is an N-bit function register (decrement, increment, load,
// clear) gated by its own enable; two independent combinational read ports
// select any entry. There is no write-to-read bypass.

// Single N-bit function register: holds unless enabled, then applies fun_sel.
module func_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e,
  input  logic [1:0]   fun_sel,
  input  logic [N-1:0] i,
  output logic [N-1:0] q
);
  localparam logic [1:0] FUN_DEC   = 2'b00;
  localparam logic [1:0] FUN_INC   = 2'b01;
  localparam logic [1:0] FUN_LOAD  = 2'b10;
  localparam logic [1:0] FUN_CLEAR = 2'b11;

  localparam logic [N-1:0] ONE = N'(1);

  // Reset clears immediately; otherwise an enabled register applies its
  // function on the rising edge and wraps mod 2^N. Unknown selects hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (e) begin
      case (fun_sel)
        FUN_DEC:   q <= q - ONE;
        FUN_INC:   q <= q + ONE;
        FUN_LOAD:  q <= i;
        FUN_CLEAR: q <= '0;
        default:   q <= q;
      endcase
    end
  end
endmodule

// Top level: four function registers sharing one write bus, two read muxes.
module reg_file #(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);
  logic [N-1:0] regs [4];

  // Entry k (0 = R1 .. 3 = R4) is enabled by reg_sel bit 3-k, so the MSB
  // of reg_sel addresses R1 while the read selects count up from R1.
  for (genvar k = 0; k < 4; k++) begin : g_reg
    func_reg #(.N(N)) u_reg (
      .clk     (clk),
      .rst     (rst),
      .e       (bus.reg_sel[3-k]),
      .fun_sel (bus.fun_sel),
      .i       (bus.i),
      .q       (regs[k])
    );
  end

  // Read port A: plain 4:1 mux straight off the register state.
  always_comb begin
    bus.out_a = regs[0];
    case (bus.out_a_sel)
      2'b00:   bus.out_a = regs[0];
      2'b01:   bus.out_a = regs[1];
      2'b10:   bus.out_a = regs[2];
      2'b11:   bus.out_a = regs[3];
      default: bus.out_a = regs[0];
    endcase
  end

  // Read port B: independent mux, may select the same entry as port A.
  always_comb begin
    bus.out_b = regs[0];
    case (bus.out_b_sel)
      2'b00:   bus.out_b = regs[0];
      2'b01:   bus.out_b = regs[1];
      2'b10:   bus.out_b = regs[2];
      2'b11:   bus.out_b = regs[3];
      default: bus.out_b = regs[0];
    endcase
  end
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vectors with literal
// expectations plus a behavioural register model checked every negedge.
module tb_reg_file;
  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  bit   checkEn;

  logic [7:0] model [4];

  reg_file_if #(.N(8)) bus ();

  reg_file #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents as the spec describes them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) model[r] = 8'h00;
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (bus.reg_sel[3-r] === 1'b1) begin
          case (bus.fun_sel)
            2'd0: model[r] = 8'((int'(model[r]) + 255) % 256);
            2'd1: model[r] = 8'((int'(model[r]) + 1) % 256);
            2'd2: model[r] = bus.i;
            2'd3: model[r] = 8'h00;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of both ports against the model, away from edges.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_port_a", bus.out_a, model[bus.out_a_sel]);
      checkOutput("model_port_b", bus.out_b, model[bus.out_b_sel]);
    end
  end

  // Drive one cycle of stimulus, then return just after the capturing edge.
  task automatic applyStimulus(input logic [3:0] regSel, input logic [1:0] funSel,
                               input logic [7:0] data, input logic [1:0] aSel,
                               input logic [1:0] bSel);
    bus.reg_sel   = regSel;
    bus.fun_sel   = funSel;
    bus.i         = data;
    bus.out_a_sel = aSel;
    bus.out_b_sel = bSel;
    @(posedge clk);
    #1;
    bus.reg_sel = 4'b0000;
  endtask

  // Read every register through both ports and compare with literals.
  task automatic checkAll(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int s = 0; s < 4; s++) begin
      bus.out_a_sel = 2'(s);
      bus.out_b_sel = 2'(3 - s);
      #1;
      checkOutput($sformatf("%s_a_sel%0d", name, s), bus.out_a, exp[s]);
      checkOutput($sformatf("%s_b_sel%0d", name, 3 - s), bus.out_b, exp[3-s]);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    checkEn     = 1'b0;
    rst           = 1'b1;
    bus.reg_sel   = 4'b0000;
    bus.fun_sel   = 2'b00;
    bus.i         = 8'h00;
    bus.out_a_sel = 2'b00;
    bus.out_b_sel = 2'b11;
    #2;
    checkAll("por", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;

    // Asynchronous reset mid-cycle, and reset dominating an enabled load.
    applyStimulus(4'b1111, 2'b10, 8'h5A, 2'b00, 2'b11);
    checkAll("load5a", 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    bus.reg_sel = 4'b1111;
    bus.fun_sel = 2'b10;
    bus.i       = 8'h5A;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_a", bus.out_a, 8'h00);
    checkOutput("rst_async_b", bus.out_b, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("rst_held_a", bus.out_a, 8'h00);
    checkOutput("rst_held_b", bus.out_b, 8'h00);
    rst = 1'b0;
    bus.reg_sel = 4'b0000;
    checkAll("rst_release", 8'h00, 8'h00, 8'h00, 8'h00);

    // Load into R1 only, then sweep selects.
    applyStimulus(4'b1000, 2'b10, 8'hAA, 2'b00, 2'b00);
    checkAll("load_r1", 8'hAA, 8'h00, 8'h00, 8'h00);

    // Increment wrap and decrement wrap on R2.
    applyStimulus(4'b0100, 2'b10, 8'hFF, 2'b01, 2'b01);
    applyStimulus(4'b0100, 2'b01, 8'h00, 2'b01, 2'b01);
    checkAll("inc_wrap", 8'hAA, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'b0100, 2'b00, 8'h00, 2'b01, 2'b01);
    checkAll("dec_wrap", 8'hAA, 8'hFF, 8'h00, 8'h00);

    // Multi-select increment on R1 and R4.
    applyStimulus(4'b1000, 2'b10, 8'h10, 2'b00, 2'b11);
    applyStimulus(4'b0001, 2'b10, 8'h20, 2'b00, 2'b11);
    applyStimulus(4'b1001, 2'b01, 8'h77, 2'b00, 2'b11);
    checkAll("multi_inc", 8'h11, 8'hFF, 8'h00, 8'h21);

    // Clear R2/R3 from all-0xAA, then RegSel=0000 holds under every function.
    applyStimulus(4'b1111, 2'b10, 8'hAA, 2'b00, 2'b01);
    applyStimulus(4'b0110, 2'b11, 8'hAA, 2'b00, 2'b01);
    checkAll("clear_r2r3", 8'hAA, 8'h00, 8'h00, 8'hAA);
    for (int f = 0; f < 4; f++) applyStimulus(4'b0000, 2'(f), 8'h33, 2'(f), 2'(3 - f));
    checkAll("hold_none", 8'hAA, 8'h00, 8'h00, 8'hAA);

    // Exhaustive sweep against the model.
    for (int rs = 0; rs < 16; rs++)
      for (int fs = 0; fs < 4; fs++)
        for (int s = 0; s < 4; s++)
          applyStimulus(4'(rs), 2'(fs), 8'hAA, 2'(s), 2'((s + rs) % 4));

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
